// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision floating-point definitions.
//   Field widths, exponent bias, int-to-float latency, the fp32_t field
//   layout and a packing helper. Imported by fp_int2float and by the
//   float add/normalize blocks.
package fp_pkg;

    localparam int FP_EXP_BIAS    = 127;
    localparam int FP_MANT_W      = 23;
    localparam int FP_EXP_W       = 8;
    localparam int FP_I2F_LATENCY = 4;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

    function automatic fp32_t fp_pack(input logic                 sign,
                                      input logic [FP_EXP_W-1:0]  exp,
                                      input logic [FP_MANT_W-1:0] mant);
        fp32_t f;
        f.sign = sign;
        f.exp  = exp;
        f.mant = mant;
        return f;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero counter.
//   value    in  W        : operand, bit W-1 is the most significant
//   count    out clog2(W+1): number of zeros above the highest set bit
//                           (W when value is zero)
//   all_zero out 1        : value is zero
module fp_lzc #(
    parameter int W = 32
) (
    input  logic [W-1:0]             value,
    output logic [$clog2(W+1)-1:0]   count,
    output logic                     all_zero
);

    localparam int CW = $clog2(W+1);

    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

    assign all_zero = ~|value;

endmodule

// File: rtl/fp_int2float.sv
// fp_int2float: signed fixed-point / integer to IEEE-754 single precision.
//   result = dataa * 2^-FRAC_BITS, round-to-nearest-even, fixed 4 enabled
//   cycles from acceptance of start to done.
// Ports:
//   clock   in  1        : rising-edge clock
//   resetn  in  1        : asynchronous active-low reset
//   clk_en  in  1        : low freezes every register
//   start   in  1        : conversion request (ignored while busy)
//   dataa   in  IN_WIDTH : signed two's-complement input
//   result  out 32       : single-precision result, held between done pulses
//   done    out 1        : one enabled cycle pulse when result is new
//   busy    out 1        : conversion in flight
// Build option: define FP_I2F_PIPELINED_EN for a fully pipelined variant
//   that accepts start every enabled cycle with busy tied low.
module fp_int2float
    import fp_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int FRAC_BITS = 0
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                clk_en,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] dataa,
    output logic [31:0]         result,
    output logic                done,
    output logic                busy
);

    localparam int LZ_W    = $clog2(IN_WIDTH + 1);
    localparam int EXP_TOP = FP_EXP_BIAS + IN_WIDTH - 1 - FRAC_BITS;
    localparam int EW      = IN_WIDTH + 32;

    if (IN_WIDTH < 2 || IN_WIDTH > 32) begin : g_bad_in_width
        $error("fp_int2float: IN_WIDTH must be in 2..32");
    end
    if (FRAC_BITS < 0 || FRAC_BITS > 126) begin : g_bad_frac_bits
        $error("fp_int2float: FRAC_BITS must be in 0..126");
    end

    // Pads the normalized magnitude with zeros so the 23 mantissa bits plus
    // guard/round/sticky always exist, whatever IN_WIDTH is.
    function automatic fp32_t round_pack(input logic                sign,
                                         input logic [IN_WIDTH-1:0] norm,
                                         input logic [7:0]          exp,
                                         input logic                zero);
        logic [EW-1:0] ext;
        logic [22:0]   mant;
        logic [23:0]   sum;
        logic          g, r, s, up;
        logic [7:0]    exp_r;
        ext   = {norm, 32'b0};
        mant  = ext[EW-2 -: 23];
        g     = ext[EW-25];
        r     = ext[EW-26];
        s     = |ext[EW-27:0];
        up    = g & (r | s | mant[0]);
        sum   = {1'b0, mant} + {23'b0, up};
        exp_r = exp;
        if (sum[23]) begin
            exp_r = exp + 8'd1;
        end
        if (zero) begin
            return fp_pack(1'b0, 8'd0, 23'd0);
        end
        return fp_pack(sign, exp_r, sum[22:0]);
    endfunction

    logic                vld_p1_q, vld_p2_q, vld_p3_q;
    logic                vld_p1_d, vld_p2_d, vld_p3_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [31:0]         result_q, result_d;
    logic                accept;

    logic                sign_p1_q, sign_p1_d;
    logic [IN_WIDTH-1:0] mag_p1_q, mag_p1_d;
    logic                sign_p2_q, sign_p2_d;
    logic [IN_WIDTH-1:0] mag_p2_q, mag_p2_d;
    logic [LZ_W-1:0]     lz_p2_q, lz_p2_d;
    logic                zero_p2_q, zero_p2_d;
    logic                sign_p3_q, sign_p3_d;
    logic [IN_WIDTH-1:0] norm_p3_q, norm_p3_d;
    logic [7:0]          exp_p3_q, exp_p3_d;
    logic                zero_p3_q, zero_p3_d;

    logic [LZ_W-1:0]     lz_cnt;
    logic                lz_zero;

    fp_lzc #(.W(IN_WIDTH)) u_lzc (
        .value    (mag_p1_q),
        .count    (lz_cnt),
        .all_zero (lz_zero)
    );

    always_comb begin
`ifdef FP_I2F_PIPELINED_EN
        accept = start;
        busy_d = 1'b0;
`else
        accept = start & ~busy_q;
        busy_d = busy_q;
        if (clk_en) begin
            if (accept) begin
                busy_d = 1'b1;
            end else if (vld_p3_q) begin
                busy_d = 1'b0;
            end
        end
`endif
        vld_p1_d  = vld_p1_q;
        vld_p2_d  = vld_p2_q;
        vld_p3_d  = vld_p3_q;
        done_d    = done_q;
        result_d  = result_q;
        sign_p1_d = sign_p1_q;
        mag_p1_d  = mag_p1_q;
        sign_p2_d = sign_p2_q;
        mag_p2_d  = mag_p2_q;
        lz_p2_d   = lz_p2_q;
        zero_p2_d = zero_p2_q;
        sign_p3_d = sign_p3_q;
        norm_p3_d = norm_p3_q;
        exp_p3_d  = exp_p3_q;
        zero_p3_d = zero_p3_q;
        if (clk_en) begin
            // S1: capture sign and magnitude; -2^(IN_WIDTH-1) still fits unsigned
            vld_p1_d  = accept;
            sign_p1_d = dataa[IN_WIDTH-1];
            mag_p1_d  = dataa[IN_WIDTH-1] ? (~dataa + {{(IN_WIDTH-1){1'b0}}, 1'b1}) : dataa;
            // S2: leading-zero count
            vld_p2_d  = vld_p1_q;
            sign_p2_d = sign_p1_q;
            mag_p2_d  = mag_p1_q;
            lz_p2_d   = lz_cnt;
            zero_p2_d = lz_zero;
            // S3: normalize and form the biased exponent
            vld_p3_d  = vld_p2_q;
            sign_p3_d = sign_p2_q;
            norm_p3_d = mag_p2_q << lz_p2_q;
            exp_p3_d  = 8'(EXP_TOP) - 8'(lz_p2_q);
            zero_p3_d = zero_p2_q;
            // S4: round and pack
            done_d    = vld_p3_q;
            if (vld_p3_q) begin
                result_d = round_pack(sign_p3_q, norm_p3_q, exp_p3_q, zero_p3_q);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Datapath registers carry no reset; their valids qualify them.
    always_ff @(posedge clock) begin
        sign_p1_q <= sign_p1_d;
        mag_p1_q  <= mag_p1_d;
        sign_p2_q <= sign_p2_d;
        mag_p2_q  <= mag_p2_d;
        lz_p2_q   <= lz_p2_d;
        zero_p2_q <= zero_p2_d;
        sign_p3_q <= sign_p3_d;
        norm_p3_q <= norm_p3_d;
        exp_p3_q  <= exp_p3_d;
        zero_p3_q <= zero_p3_d;
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_fp_int2float.sv
// tb_fp_int2float: directed bench for fp_int2float.
//   Two instances: IN_WIDTH=32/FRAC_BITS=0 and IN_WIDTH=24/FRAC_BITS=23.
//   Covers reset state, conversions with rounding corners, latency,
//   handshake (single-issue or FP_I2F_PIPELINED_EN), clk_en freeze and
//   asynchronous reset mid-conversion.
module tb_fp_int2float;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        clk_en = 1'b1;
    logic        start32 = 1'b0;
    logic [31:0] dataa32 = 32'd0;
    logic [31:0] result32;
    logic        done32, busy32;
    logic        start24 = 1'b0;
    logic [23:0] dataa24 = 24'd0;
    logic [31:0] result24;
    logic        done24, busy24;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    fp_int2float #(.IN_WIDTH(32), .FRAC_BITS(0)) u_dut32 (
        .clock  (clock),
        .resetn (resetn),
        .clk_en (clk_en),
        .start  (start32),
        .dataa  (dataa32),
        .result (result32),
        .done   (done32),
        .busy   (busy32)
    );

    fp_int2float #(.IN_WIDTH(24), .FRAC_BITS(23)) u_dut24 (
        .clock  (clock),
        .resetn (resetn),
        .clk_en (clk_en),
        .start  (start24),
        .dataa  (dataa24),
        .result (result24),
        .done   (done24),
        .busy   (busy24)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One conversion: start for one cycle, wait (bounded) for done.
    task automatic conv(input bit w24, input logic [31:0] d, input logic [31:0] expv,
                        input string tag);
        int   cyc;
        logic dn;
        @(negedge clock);
        if (w24) begin
            start24 = 1'b1;
            dataa24 = d[23:0];
        end else begin
            start32 = 1'b1;
            dataa32 = d;
        end
        @(negedge clock);
        start24 = 1'b0;
        start32 = 1'b0;
        cyc = 1;
        dn = w24 ? done24 : done32;
        while (!dn && cyc < 20) begin
            @(negedge clock);
            cyc++;
            dn = w24 ? done24 : done32;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'd4);
        chk(tag, w24 ? result24 : result32, expv);
    endtask

    initial begin
        int   cyc, ndone, first;
        logic busy_k5;
        logic [31:0] r1;

        repeat (3) @(negedge clock);
        chk("rst_result32", result32, 32'd0);
        chk("rst_done32", {31'd0, done32}, 32'd0);
        chk("rst_busy32", {31'd0, busy32}, 32'd0);
        chk("rst_result24", result24, 32'd0);
        chk("rst_done24", {31'd0, done24}, 32'd0);
        resetn = 1'b1;

        conv(1'b0, 32'd1,        32'h3F80_0000, "one");
        conv(1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, "minus_one");
        conv(1'b0, 32'd0,        32'h0000_0000, "zero");
        conv(1'b0, 32'd16777217, 32'h4B80_0000, "tie_down");
        conv(1'b0, 32'd16777219, 32'h4B80_0002, "tie_up");
        conv(1'b0, 32'h7FFF_FFFF, 32'h4F00_0000, "carry");
        conv(1'b0, 32'h8000_0000, 32'hCF00_0000, "most_neg");
        conv(1'b0, 32'd3,        32'h4040_0000, "three");
        conv(1'b1, 32'h0040_0000, 32'h3F00_0000, "q23_half");
        conv(1'b1, 32'h0080_0000, 32'hBF80_0000, "q23_min");
        conv(1'b1, 32'h0000_0001, 32'h3400_0000, "q23_lsb");

        @(negedge clock);
`ifdef FP_I2F_PIPELINED_EN
        start32 = 1'b1;
        dataa32 = 32'd1;
        @(negedge clock);
        dataa32 = 32'd2;
        @(negedge clock);
        dataa32 = 32'd3;
        @(negedge clock);
        start32 = 1'b0;
        cyc = 3;
        while (!done32 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        chk("pipe_lat", 32'(cyc), 32'd4);
        chk("pipe_r1", result32, 32'h3F80_0000);
        @(negedge clock);
        chk("pipe_d2", {31'd0, done32}, 32'd1);
        chk("pipe_r2", result32, 32'h4000_0000);
        @(negedge clock);
        chk("pipe_d3", {31'd0, done32}, 32'd1);
        chk("pipe_r3", result32, 32'h4040_0000);
        @(negedge clock);
        chk("pipe_end", {31'd0, done32}, 32'd0);
`else
        start32 = 1'b1;
        dataa32 = 32'd5;
        ndone = 0;
        first = 0;
        busy_k5 = 1'b0;
        r1 = 32'd0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (k == 1) dataa32 = 32'd7;
            if (done32) begin
                ndone++;
                if (first == 0) first = k;
                r1 = result32;
            end
            if (k == 5) busy_k5 = busy32;
        end
        start32 = 1'b0;
        chk("hs_ndone", 32'(ndone), 32'd1);
        chk("hs_first", 32'(first), 32'd4);
        chk("hs_res", r1, 32'h40A0_0000);
        chk("hs_reaccept", {31'd0, busy_k5}, 32'd1);
        cyc = 6;
        while (!done32 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        chk("hs2_lat", 32'(cyc), 32'd8);
        chk("hs2_res", result32, 32'h40E0_0000);
`endif

        // clk_en freeze mid-conversion, then while done is high
        @(negedge clock);
        start32 = 1'b1;
        dataa32 = 32'hFFFF_FFFE;
        @(negedge clock);
        start32 = 1'b0;
        cyc = 1;
        @(negedge clock);
        cyc++;
        clk_en = 1'b0;
        repeat (3) begin
            @(negedge clock);
            cyc++;
        end
        chk("fz_nodone", {31'd0, done32}, 32'd0);
        clk_en = 1'b1;
        while (!done32 && cyc < 30) begin
            @(negedge clock);
            cyc++;
        end
        chk("fz_lat", 32'(cyc), 32'd7);
        chk("fz_res", result32, 32'hC000_0000);
        clk_en = 1'b0;
        repeat (2) @(negedge clock);
        chk("fz_done_hold", {31'd0, done32}, 32'd1);
        clk_en = 1'b1;
        @(negedge clock);
        chk("fz_done_clr", {31'd0, done32}, 32'd0);

        // asynchronous reset while the conversion sits in S2
        start32 = 1'b1;
        dataa32 = 32'd5;
        @(negedge clock);
        start32 = 1'b0;
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("ar_result", result32, 32'd0);
        chk("ar_done", {31'd0, done32}, 32'd0);
        chk("ar_busy", {31'd0, busy32}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(negedge clock);
            if (done32) ndone++;
        end
        chk("ar_nodone", 32'(ndone), 32'd0);
        conv(1'b0, 32'd2, 32'h4000_0000, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
